// File: rtl/rc5_iter_core_if.sv
// Block, result and round-key port bundle for rc5_iter_core.
// The master drives the block and key inputs; the slave is the core.
interface rc5_iter_core_if #(
    parameter int W = 32,
    parameter int R = 12
);
    localparam int NK  = 2 * R + 2;
    localparam int KAW = $clog2(NK);

    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] din;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] dout;
    logic           key_we;
    logic [KAW-1:0] key_addr;
    logic [W-1:0]   key_data;
    logic           key_wr_err;
    logic           busy;

    modport master (
        output mode, in_valid, din, out_ready, key_we, key_addr, key_data,
        input  in_ready, out_valid, dout, key_wr_err, busy
    );

    modport slave (
        input  mode, in_valid, din, out_ready, key_we, key_addr, key_data,
        output in_ready, out_valid, dout, key_wr_err, busy
    );
endinterface

// File: rtl/rc5_iter_core.sv
// Iterative RC5 encrypt/decrypt core: one full round per clock.
// The round-key table is loaded externally through the key port.
module rc5_iter_core #(
    parameter int W = 32,
    parameter int R = 12
) (
    input  logic            clk,
    input  logic            rst,
    rc5_iter_core_if.slave  bus
);
    localparam int LGW = $clog2(W);
    localparam int NK  = 2 * R + 2;
    localparam int KAW = $clog2(NK);

    localparam logic [KAW:0]   NK_LIM = (KAW + 1)'(NK);
    localparam logic [KAW-1:0] I_LAST = KAW'(R);
    localparam logic [KAW-1:0] I_ONE  = KAW'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WHITEN   = 3'd1;
    localparam logic [2:0] ROUND    = 3'd2;
    localparam logic [2:0] UNWHITEN = 3'd3;
    localparam logic [2:0] OUT      = 3'd4;

    logic [2:0]     state;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [KAW-1:0] i;
    logic           dec;
    logic           ready_en;
    logic           err;
    logic [W-1:0]   s [NK];

    logic           accept_ok;
    logic [KAW-1:0] k_even;
    logic [KAW-1:0] k_odd;
    logic [W-1:0]   s_even;
    logic [W-1:0]   s_odd;
    logic [W-1:0]   a_enc;
    logic [W-1:0]   b_enc;
    logic [W-1:0]   a_dec;
    logic [W-1:0]   b_dec;

    // {x,x} shifted keeps the wrapped-around bits in the selected half
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return W'(({x, x} << n) >> W);
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return W'({x, x} >> n);
    endfunction

    // ready_en keeps in_ready low until the first edge after reset release
    assign accept_ok = ready_en && (state == IDLE) && !bus.key_we;

    assign k_even = {i[KAW-2:0], 1'b0};
    assign k_odd  = {i[KAW-2:0], 1'b1};
    assign s_even = s[k_even];
    assign s_odd  = s[k_odd];

    assign a_enc = rotl(a ^ b, b[LGW-1:0]) + s_even;
    assign b_enc = rotl(b ^ a_enc, a_enc[LGW-1:0]) + s_odd;
    assign b_dec = rotr(b - s_odd, a[LGW-1:0]) ^ a;
    assign a_dec = rotr(a - s_even, b_dec[LGW-1:0]) ^ b_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            i        <= '0;
            dec      <= 1'b0;
            ready_en <= 1'b0;
            err      <= 1'b0;
            for (int k = 0; k < NK; k++) s[k] <= '0;
        end else begin
            ready_en <= 1'b1;
            err      <= 1'b0;
            if (bus.key_we) begin
                if (state == IDLE && {1'b0, bus.key_addr} < NK_LIM)
                    s[bus.key_addr] <= bus.key_data;
                else
                    err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid && accept_ok) begin
                        a   <= bus.din[W-1:0];
                        b   <= bus.din[2*W-1:W];
                        dec <= bus.mode;
                        if (bus.mode) begin
                            state <= ROUND;
                            i     <= I_LAST;
                        end else begin
                            state <= WHITEN;
                            i     <= I_ONE;
                        end
                    end
                end
                WHITEN: begin
                    a     <= a + s[0];
                    b     <= b + s[1];
                    state <= ROUND;
                end
                ROUND: begin
                    if (!dec) begin
                        a <= a_enc;
                        b <= b_enc;
                        if (i == I_LAST) state <= OUT;
                        else             i     <= i + I_ONE;
                    end else begin
                        a <= a_dec;
                        b <= b_dec;
                        if (i == I_ONE) state <= UNWHITEN;
                        else            i     <= i - I_ONE;
                    end
                end
                UNWHITEN: begin
                    b     <= b - s[1];
                    a     <= a - s[0];
                    state <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = accept_ok;
    assign bus.out_valid  = (state == OUT);
    assign bus.dout       = (state == OUT) ? {b, a} : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.key_wr_err = err;
endmodule

// File: doc/rc5_iter_core.md
RC5_ITER_CORE -- requirements
Module: rc5_iter_core

Interface
REQ-001 Parameter W, default 32: word width in bits; legal values are 16, 32 and 64; the data block is 2W bits.
REQ-002 Parameter R, default 12: round count; legal range is 1..255.
REQ-003 Derived value LGW = log2(W) is the rotate-amount width; NK = 2R+2 is the round-key count; KAW = ceil(log2(NK)) is the key address width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 mode  in  1  0 = encrypt, 1 = decrypt; sampled only at input acceptance.
REQ-007 in_valid  in  1  input block offered.
REQ-008 in_ready  out  1  core can accept a block.
REQ-009 din  in  2W  input block; din[W-1:0] is A and din[2W-1:W] is B.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 dout  out  2W  result block, packed the same way as din.
REQ-013 key_we  in  1  round-key table write strobe.
REQ-014 key_addr  in  KAW  round-key index S[key_addr].
REQ-015 key_data  in  W  round-key value.
REQ-016 key_wr_err  out  1  one-cycle pulse when a key write is rejected.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The core SHALL hold an internal table S[0..NK-1] of W-bit round keys, written only through the key port; the key schedule is computed outside this block.
REQ-019 A key write SHALL take effect at the clock edge only when state is IDLE and key_addr < NK.
- Otherwise the write is dropped and key_wr_err is high for the following cycle.
REQ-020 in_ready SHALL equal (state == IDLE) AND NOT key_we.
- A simultaneous key_we and in_valid in IDLE performs the write and does not accept the block.
REQ-021 The state machine SHALL have states IDLE, WHITEN, ROUND, UNWHITEN and OUT.
REQ-022 On an edge with in_valid & in_ready, the core SHALL:
- latch A, B and mode;
- go to WHITEN if encrypting, with round counter i = 1;
- go to ROUND if decrypting, with i = R.
REQ-023 WHITEN (encrypt) SHALL compute A = A + S[0] and B = B + S[1], then go to ROUND.
REQ-024 ROUND (encrypt) SHALL perform one full round per cycle:
- A' = ((A ^ B) <<< B[LGW-1:0]) + S[2i];
- B' = ((B ^ A') <<< A'[LGW-1:0]) + S[2i+1];
- i increments; after i = R, go to OUT.
REQ-025 ROUND (decrypt) SHALL perform one full round per cycle:
- B' = ((B - S[2i+1]) >>> A[LGW-1:0]) ^ A;
- A' = ((A - S[2i]) >>> B'[LGW-1:0]) ^ B';
- i decrements; after i = 1, go to UNWHITEN.
REQ-026 UNWHITEN (decrypt) SHALL compute B = B - S[1] and A = A - S[0], then go to OUT.
REQ-027 All additions and subtractions SHALL be modulo 2^W; rotates are circular over W bits; a rotate by 0 is identity.
REQ-028 out_valid SHALL be high exactly in OUT, and exactly R+1 cycles after the acceptance edge for both modes.
REQ-029 dout SHALL equal {B, A} in OUT and hold stable until out_ready is sampled high; it is 0 in all other states.
REQ-030 OUT & out_ready SHALL return to IDLE; in_ready is therefore high no earlier than the cycle after the handshake, giving a throughput of one block per R+3 cycles minimum.
REQ-031 in_valid, din and mode changes SHALL be ignored outside IDLE.

Reset
REQ-032 Asserting rst low SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- clear A, B, i and every S entry to 0;
- drive in_ready=0, out_valid=0, dout=0, busy=0, key_wr_err=0.
REQ-033 In-flight operations SHALL be abandoned without output when reset is asserted mid-operation; after rst deasserts, in_ready rises on the first edge in IDLE.

Verification
REQ-034 W=32, R=12, S loaded with the schedule of the all-zero 16-byte key, encrypt din=0 -> dout=0x6D8F4B15_EEDBA521 with out_valid asserted 13 cycles after acceptance.
REQ-035 Same S, decrypt din=0x6D8F4B15_EEDBA521 -> dout=0; then 1000 random blocks encrypt-then-decrypt round-trip to the original, also at W=16/R=1 and W=64/R=20 against a software model.
REQ-036 Hold out_ready=0 for 5 cycles in OUT -> dout and out_valid stable, in_ready=0, busy=1; out_ready=1 -> IDLE on the next edge.
REQ-037 Key write while busy, and key_addr=NK in IDLE -> S unchanged, key_wr_err=1 for one cycle each; key_we with in_valid in IDLE -> write done, block not accepted.
REQ-038 rst low asynchronously in ROUND at i=6 -> outputs 0 before the next edge; after release, a fresh encrypt matches the model.
